// File: rtl/ifid_pkg.sv
// rtl/ifid_pkg.sv - shared constants and entry type for the IF/ID decoupling queue
package ifid_pkg;

  // Default queue depth (power of two, >= 2)
  localparam int DEFAULT_DEPTH = 4;

  // Canonical NOP shown to decode when the queue is empty: add $0,$0,$0
  localparam logic [31:0] NOP_INST = 32'h0000_0020;

  // One fetched instruction as carried from IF to ID (default 32-bit widths)
  typedef struct packed {
    logic [31:0] pcplus4;
    logic [31:0] inst;
    logic        btb_hit;
    logic        taken;
  } ifid_entry_t;

endpackage

// File: rtl/ifid_queue_mem.sv
// rtl/ifid_queue_mem.sv - DEPTH x WIDTH register array, one write port, async read port
module ifid_queue_mem #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 66
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Storage write; contents need no reset because occupancy gates every read
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/ifid_queue.sv
// rtl/ifid_queue.sv - IF/ID circular queue with flush and NOP fill; IFID_QUEUE_PERF_EN adds perf counters
module ifid_queue
  import ifid_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = 32,
  parameter int IW    = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [AW-1:0]                in_pcplus4,
  input  logic [IW-1:0]                in_inst,
  input  logic                         in_btb_hit,
  input  logic                         in_taken,
  input  logic                         flush,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [AW-1:0]                out_pcplus4,
  output logic [IW-1:0]                out_inst,
  output logic                         out_btb_hit,
  output logic                         out_taken,
  output logic [$clog2(DEPTH+1)-1:0]   count
`ifdef IFID_QUEUE_PERF_EN
  ,
  output logic [31:0]                  stall_cycles,
  output logic [31:0]                  flushed_entries
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = AW + IW + 2;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C      = CW'(1);
  localparam logic [PW-1:0] ONE_P      = PW'(1);

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic          w_push;
  logic          w_pop;
  logic [EW-1:0] w_wdata;
  logic [EW-1:0] w_rdata;

  // Ready and valid depend on occupancy only, so a full queue never takes a
  // same-cycle entry even when decode pops
  assign in_ready  = (r_count != FULL_COUNT);
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;
  assign count     = r_count;

  assign w_wdata = {in_pcplus4, in_inst, in_btb_hit, in_taken};

  ifid_queue_mem #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_mem (
    .clk   (clk),
    .we    (w_push & ~flush),
    .waddr (r_wr_ptr),
    .wdata (w_wdata),
    .raddr (r_rd_ptr),
    .rdata (w_rdata)
  );

  // Pointer and occupancy tracking; flush overrides push and pop
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + ONE_P;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + ONE_P;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + ONE_C;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - ONE_C;
      end
    end
  end

  // Head fields, forced to a clean NOP when nothing is queued so decode never sees X
  assign out_pcplus4 = out_valid ? w_rdata[EW-1 -: AW]     : '0;
  assign out_inst    = out_valid ? w_rdata[IW+1 -: IW]     : IW'(NOP_INST);
  assign out_btb_hit = out_valid ? w_rdata[1]              : 1'b0;
  assign out_taken   = out_valid ? w_rdata[0]              : 1'b0;

`ifdef IFID_QUEUE_PERF_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_flushed_entries;

  // Fetch back-pressure cycles and entries discarded by flushes (both wrap)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cycles    <= '0;
      r_flushed_entries <= '0;
    end else begin
      if (in_valid && !in_ready) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end
      if (flush) begin
        r_flushed_entries <= r_flushed_entries + 32'(r_count);
      end
    end
  end

  assign stall_cycles    = r_stall_cycles;
  assign flushed_entries = r_flushed_entries;
`endif

endmodule

// File: tb/tb_ifid_queue.sv
// tb/tb_ifid_queue.sv - randomized self-checking bench for ifid_queue against a queue model
module tb_ifid_queue;
  import ifid_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pcplus4 = '0;
  logic [31:0] in_inst = '0;
  logic        in_btb_hit = 1'b0;
  logic        in_taken = 1'b0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pcplus4;
  logic [31:0] out_inst;
  logic        out_btb_hit;
  logic        out_taken;
  logic [2:0]  count;
`ifdef IFID_QUEUE_PERF_EN
  logic [31:0] stall_cycles;
  logic [31:0] flushed_entries;
`endif

  ifid_queue #(.DEPTH(DEPTH), .AW(32), .IW(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_pcplus4  (in_pcplus4),
    .in_inst     (in_inst),
    .in_btb_hit  (in_btb_hit),
    .in_taken    (in_taken),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pcplus4 (out_pcplus4),
    .out_inst    (out_inst),
    .out_btb_hit (out_btb_hit),
    .out_taken   (out_taken),
    .count       (count)
`ifdef IFID_QUEUE_PERF_EN
    ,
    .stall_cycles    (stall_cycles),
    .flushed_entries (flushed_entries)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  ifid_entry_t model_q[$];
  int unsigned m_stall   = 0;
  int unsigned m_flushed = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    int sz;
    sz = model_q.size();
    check_eq("count", 64'(count), 64'(sz));
    check_eq("in_ready", 64'(in_ready), 64'(sz != DEPTH));
    check_eq("out_valid", 64'(out_valid), 64'(sz != 0));
    if (sz != 0) begin
      check_eq("out_pcplus4", 64'(out_pcplus4), 64'(model_q[0].pcplus4));
      check_eq("out_inst", 64'(out_inst), 64'(model_q[0].inst));
      check_eq("out_btb_hit", 64'(out_btb_hit), 64'(model_q[0].btb_hit));
      check_eq("out_taken", 64'(out_taken), 64'(model_q[0].taken));
    end else begin
      check_eq("out_pcplus4_empty", 64'(out_pcplus4), 64'(0));
      check_eq("out_inst_nop", 64'(out_inst), 64'(32'h0000_0020));
      check_eq("out_btb_hit_empty", 64'(out_btb_hit), 64'(0));
      check_eq("out_taken_empty", 64'(out_taken), 64'(0));
    end
`ifdef IFID_QUEUE_PERF_EN
    check_eq("stall_cycles", 64'(stall_cycles), 64'(m_stall));
    check_eq("flushed_entries", 64'(flushed_entries), 64'(m_flushed));
`endif
  endtask

  // One clock: check state at the falling edge, drive inputs, then advance the model at the rising edge
  task automatic cycle(input logic iv, input logic [31:0] pc, input logic [31:0] ins,
                       input logic bh, input logic tk, input logic ordy, input logic fl);
    bit accept;
    bit take;
    ifid_entry_t e;
    @(negedge clk);
    check_outputs();
    in_valid   = iv;
    in_pcplus4 = pc;
    in_inst    = ins;
    in_btb_hit = bh;
    in_taken   = tk;
    out_ready  = ordy;
    flush      = fl;
    @(posedge clk);
    accept = iv && (model_q.size() < DEPTH);
    take   = ordy && (model_q.size() > 0);
    if (iv && !(model_q.size() < DEPTH)) m_stall++;
    if (fl) m_flushed += model_q.size();
    if (fl) begin
      model_q.delete();
    end else begin
      if (take) void'(model_q.pop_front());
      if (accept) begin
        e.pcplus4 = pc;
        e.inst    = ins;
        e.btb_hit = bh;
        e.taken   = tk;
        model_q.push_back(e);
      end
    end
  endtask

  task automatic idle_inputs();
    in_valid   = 1'b0;
    in_pcplus4 = '0;
    in_inst    = '0;
    in_btb_hit = 1'b0;
    in_taken   = 1'b0;
    out_ready  = 1'b0;
    flush      = 1'b0;
  endtask

  initial begin
    logic [31:0] prev_pc;

    // Reset held for two cycles, then idle
    idle_inputs();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs();
    reset = 1'b1;
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Fill with decode stalled, attempt a fifth push, then drain
    for (int i = 1; i <= 4; i++) begin
      cycle(1'b1, 32'(4 * i), $urandom, 1'(i), 1'(i >> 1), 1'b0, 1'b0);
    end
    cycle(1'b1, 32'h14, 32'h0000_DEAD, 1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("full_count", 64'(count), 64'(4));
    check_eq("full_in_ready", 64'(in_ready), 64'(0));
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    end

    // Streaming: push and pop every cycle starting empty
    prev_pc = 32'h0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) begin
        @(negedge clk);
        check_eq("stream_pc", 64'(out_pcplus4), 64'(prev_pc));
        check_eq("stream_count", 64'(count), 64'(1));
      end
      prev_pc = 32'h100 + 32'(4 * i);
      cycle(1'b1, prev_pc, $urandom, 1'($urandom), 1'($urandom), 1'b1, 1'b0);
    end
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Wrap-around from a pointer reset: bursts of three pushes then three pops
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 3; i++) begin
        cycle(1'b1, 32'h200 + 32'(4 * (3 * b + i)), $urandom, 1'($urandom), 1'($urandom), 1'b0, 1'b0);
      end
      for (int i = 0; i < 3; i++) begin
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
      end
    end

    // Flush colliding with push and pop
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 32'h300 + 32'(4 * i), $urandom, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    cycle(1'b1, 32'h3FC, 32'hBAD0_BAD0, 1'b1, 1'b1, 1'b1, 1'b1);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset between edges with two entries queued
    cycle(1'b1, 32'h400, $urandom, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 32'h404, $urandom, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check_eq("pre_reset_count", 64'(count), 64'(2));
    #2;
    idle_inputs();
    reset = 1'b0;
    #1;
    check_eq("async_out_valid", 64'(out_valid), 64'(0));
    check_eq("async_count", 64'(count), 64'(0));
    check_eq("async_out_inst", 64'(out_inst), 64'(32'h0000_0020));
`ifdef IFID_QUEUE_PERF_EN
    check_eq("async_stall_cycles", 64'(stall_cycles), 64'(0));
`endif
    model_q.delete();
    m_stall   = 0;
    m_flushed = 0;
    @(negedge clk);
    reset = 1'b1;

    // Randomized traffic with occasional flushes
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), $urandom, $urandom, 1'($urandom), 1'($urandom),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 24) == 0));
    end
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
